// File: rtl/lcd_init_seq_if.sv
// lcd_init_seq_if
//   Command/handshake bundle between lcd_init_seq and its neighbours.
//   Signals:
//     tfsm_state  state of the downstream LCD timing FSM (0 = idle)
//     tfsm_en     one-cycle start pulse to the timing FSM
//     cmd_byte    byte for the timing FSM to transfer
//     cmd_rs      register select for cmd_byte
//     user_valid  user write request
//     user_byte   user data or command byte
//     user_rs     user register select
//     user_ready  request accepted when high together with user_valid
//   master: the sequencer side; slave: timing FSM + user side.
interface lcd_init_seq_if;
  logic [2:0] tfsm_state;
  logic       tfsm_en;
  logic [7:0] cmd_byte;
  logic       cmd_rs;
  logic       user_valid;
  logic [7:0] user_byte;
  logic       user_rs;
  logic       user_ready;

  modport master (
    input  tfsm_state, user_valid, user_byte, user_rs,
    output tfsm_en, cmd_byte, cmd_rs, user_ready
  );

  modport slave (
    output tfsm_state, user_valid, user_byte, user_rs,
    input  tfsm_en, cmd_byte, cmd_rs, user_ready
  );
endinterface

// File: rtl/lcd_init_seq.sv
// lcd_init_seq
//   HD44780-style LCD power-up sequencer. Drives the raw 4-bit init nibbles
//   (0x3,0x3,0x3,0x2) directly on the LCD pins, then issues the command list
//   0x28,0x06,0x0C,0x01 through the downstream timing FSM, waits for the
//   clear-display time and finally passes user writes through.
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          lcd_init_seq_if.master (timing FSM + user handshake)
//     init_e       LCD_E during raw-nibble init
//     init_nib     LCD data nibble during raw-nibble init
//     init_active  pin-mux select, 1 = init_e/init_nib own the LCD pins
//     init_done    high once the full init sequence has completed
module lcd_init_seq #(
  parameter int unsigned T_PWR = 750000,
  parameter int unsigned T_E   = 12,
  parameter int unsigned T_W1  = 205000,
  parameter int unsigned T_W2  = 5000,
  parameter int unsigned T_W3  = 2000,
  parameter int unsigned T_CLR = 82000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_init_seq_if.master       bus,
  output logic                 init_e,
  output logic [3:0]           init_nib,
  output logic                 init_active,
  output logic                 init_done
);

  function automatic int unsigned maxu(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter is wide enough for the longest wait, never narrower than 20 bits.
  localparam int unsigned TMAX = maxu(maxu(maxu(T_PWR, T_W1), maxu(T_W2, T_W3)),
                                      maxu(T_CLR, T_E + 32'd2));
  localparam int unsigned CLOG = $clog2(TMAX + 32'd1);
  localparam int unsigned CW   = (CLOG > 32'd20) ? CLOG : 32'd20;

  typedef enum logic [3:0] {
    PWR, N1, W1, N2, W2, N3, W3, N4, W4, CISSUE, CWAIT, CLR, READY, UWAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   dur;
  logic            last;
  logic [1:0]      idx;
  logic            seen_busy;
  logic            tfsm_idle;

  logic            en_q;
  logic [7:0]      byte_q;
  logic            rs_q;
  logic            rdy_q;

  function automatic logic [7:0] cmd_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  assign tfsm_idle = (bus.tfsm_state == 3'd0);

  // Duration of the current timed state; untimed states never consult it.
  always_comb begin
    dur = '0;
    unique case (state)
      PWR:                 dur = CW'(T_PWR);
      N1, N2, N3, N4:      dur = CW'(T_E + 32'd2);
      W1:                  dur = CW'(T_W1);
      W2:                  dur = CW'(T_W2);
      W3, W4:              dur = CW'(T_W3);
      CLR:                 dur = CW'(T_CLR);
      default:             dur = '0;
    endcase
  end

  assign last = (cnt == dur - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWR;
      cnt         <= '0;
      idx         <= '0;
      seen_busy   <= 1'b0;
      en_q        <= 1'b0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      rdy_q       <= 1'b0;
      init_e      <= 1'b0;
      init_nib    <= '0;
      init_active <= 1'b1;
      init_done   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      init_e <= 1'b0;
      cnt    <= cnt + CW'(1);

      unique case (state)
        PWR: begin
          if (last) begin
            state    <= N1;
            cnt      <= '0;
            init_nib <= 4'h3;
          end
        end

        // E rises for cycles 1..T_E of the nibble state; the registered
        // value is computed one cycle ahead from the current count.
        N1, N2, N3, N4: begin
          init_e <= (cnt < CW'(T_E));
          if (last) begin
            cnt <= '0;
            unique case (state)
              N1:      state <= W1;
              N2:      state <= W2;
              N3:      state <= W3;
              default: state <= W4;
            endcase
          end
        end

        W1, W2, W3: begin
          if (last) begin
            cnt <= '0;
            unique case (state)
              W1: begin
                state    <= N2;
                init_nib <= 4'h3;
              end
              W2: begin
                state    <= N3;
                init_nib <= 4'h3;
              end
              default: begin
                state    <= N4;
                init_nib <= 4'h2;
              end
            endcase
          end
        end

        W4: begin
          if (last) begin
            state       <= CISSUE;
            cnt         <= '0;
            idx         <= '0;
            init_nib    <= '0;
            init_active <= 1'b0;
          end
        end

        CISSUE: begin
          cnt <= '0;
          if (tfsm_idle) begin
            byte_q    <= cmd_rom(idx);
            rs_q      <= 1'b0;
            en_q      <= 1'b1;
            seen_busy <= 1'b0;
            state     <= CWAIT;
          end
        end

        // The timing FSM only leaves idle a cycle after the pulse, so an idle
        // reading counts as completion only once busy has been observed.
        CWAIT: begin
          cnt <= '0;
          if (!tfsm_idle) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            if (idx == 2'd3) begin
              state <= CLR;
            end else begin
              idx   <= idx + 2'd1;
              state <= CISSUE;
            end
          end
        end

        CLR: begin
          if (last) begin
            state     <= READY;
            cnt       <= '0;
            init_done <= 1'b1;
            rdy_q     <= 1'b1;
          end
        end

        READY: begin
          cnt <= '0;
          if (bus.user_valid && tfsm_idle) begin
            byte_q    <= bus.user_byte;
            rs_q      <= bus.user_rs;
            en_q      <= 1'b1;
            seen_busy <= 1'b0;
            rdy_q     <= 1'b0;
            state     <= UWAIT;
          end
        end

        UWAIT: begin
          cnt <= '0;
          if (!tfsm_idle) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= READY;
            rdy_q <= 1'b1;
          end
        end

        default: begin
          state <= PWR;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.tfsm_en    = en_q;
  assign bus.cmd_byte   = byte_q;
  assign bus.cmd_rs     = rs_q;
  // Ready is gated live by the timing FSM so a busy downstream blocks acceptance.
  assign bus.user_ready = rdy_q && tfsm_idle;

endmodule
